// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM access controller: FSM state encoding.
package ram_ctrl_pkg;

  // CLEAR: zero-fill sweep owns the RAM pins. RUN: requests are served.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage : ram_ctrl_pkg

// File: rtl/ram_access_ctrl.sv
// Request/response front end for a single-port async-read RAM.
// After reset the controller optionally zero-fills words 0..DEPTH-1, then
// serves read/write requests. Reads return registered data through a
// single-entry response register.
//
// Handshake: a transfer happens on a cycle where valid && ready are both 1
// at the rising edge. A producer keeps valid (and its payload) stable until
// the transfer. req_ready never depends combinationally on req_valid;
// resp_data is held stable while resp_valid && !resp_ready.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DWIDTH         = 8,
  parameter int AWIDTH         = 8,
  parameter int DEPTH          = (1 << AWIDTH),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_data,
  output logic              busy,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q
);

  // DEPTH-1 always fits in AWIDTH bits, so the sweep counter never wraps
  // before reaching the last valid word.
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  // One extra bit so DEPTH == 2^AWIDTH is representable for the range check.
  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH + 1)'(DEPTH);
  localparam state_e            RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DWIDTH-1:0]   resp_data_q, resp_data_d;

  logic                in_range;
  logic                req_fire;
  logic                rd_accept;

  assign in_range   = ({1'b0, req_addr} < DEPTH_W);
  assign busy       = (state_q == ST_CLEAR);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  // Request acceptance: blocked during the sweep; otherwise free whenever the
  // response slot is empty or being drained this cycle.
  always_comb begin
    req_ready = 1'b0;
    if (state_q == ST_RUN) begin
      req_ready = !resp_valid_q || resp_ready;
    end
  end

  assign req_fire  = req_valid && req_ready;
  assign rd_accept = req_fire && !req_we;

  // RAM pin mux: the sweep owns the pins in CLEAR; requests drive them in RUN.
  always_comb begin
    ram_addr = req_addr;
    ram_d    = req_data;
    ram_we   = req_fire && req_we && in_range;
    if (state_q == ST_CLEAR) begin
      ram_addr = clr_cnt_q;
      ram_d    = '0;
      ram_we   = 1'b1;
    end
  end

  // Next-state logic for the FSM, sweep counter and response register.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (rd_accept) begin
          // Out-of-range reads still answer, with zero data.
          resp_valid_d = 1'b1;
          resp_data_d  = in_range ? ram_q : '0;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // State registers; reset discards any pending response and restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_STATE;
      clr_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule : ram_access_ctrl

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl with an async-read RAM model, DEPTH=12 of 16 words.
module tb_ram_access_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_d, ram_q;

  ram_access_ctrl #(
    .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
  );

  // RAM model: full 2^AW words, async read; bench can poke 0xFF garbage.
  logic [DW-1:0] mem [0:15];
  logic          poke_en;
  logic [AW-1:0] poke_addr;
  assign ram_q = mem[ram_addr];
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= 8'hFF;
    else if (ram_we) mem[ram_addr] <= ram_d;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  // One write transaction; expects immediate acceptance.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_we);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_data = d;
    #1;
    check_eq("wr_ready", req_ready, 1);
    check_eq("wr_ram_we", ram_we, exp_we);
    step();
    idle_req();
  endtask

  // One read with resp_ready=1; response checked one cycle after acceptance.
  task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1;
    check_eq("rd_ready", req_ready, 1);
    step();
    idle_req();
    check_eq("rd_valid", resp_valid, 1);
    check_eq("rd_data", resp_data, exp);
    step();
    check_eq("rd_drained", resp_valid, 0);
  endtask

  // Sweep must run exactly DEPTH cycles over addr 0..DEPTH-1, then leave CLEAR.
  task automatic check_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("sw_busy", busy, 1);
      check_eq("sw_ready", req_ready, 0);
      check_eq("sw_we", ram_we, 1);
      check_eq("sw_addr", ram_addr, i);
      check_eq("sw_d", ram_d, 0);
      step();
    end
    check_eq("sw_done_busy", busy, 0);
    check_eq("sw_done_ready", req_ready, 1);
  endtask

  // Watchdog: stimulus is fixed-length, so this only trips on a bench error.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_req();
    resp_ready = 1'b1;
    poke_en    = 1'b1;
    poke_addr  = '0;

    // Fill RAM with 0xFF while reset is held, so the sweep is observable.
    for (int i = 0; i < 16; i++) begin
      poke_addr = AW'(i);
      step();
    end
    poke_en = 1'b0;
    step();              // one more edge with rst high
    rst = 1'b0;

    // 1. reset state, sweep, all-zero contents
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_sweep();
    for (int i = 0; i < DEPTH; i++) read_check(AW'(i), 8'h00);
    check_eq("mem12_untouched", mem[12], 8'hFF);

    // 2. write then read next cycle
    do_write(4'd3, 8'hA5, 1'b1);
    read_check(4'd3, 8'hA5);

    // 3. back-pressure: read @3 held, read @4 waits
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    #1;
    check_eq("bp_first_ready", req_ready, 1);
    step();
    req_addr = 4'd4;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_ready_low", req_ready, 0);
      check_eq("bp_valid", resp_valid, 1);
      check_eq("bp_hold_data", resp_data, 8'hA5);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check_eq("bp_ready_back", req_ready, 1);
    step();
    idle_req();
    check_eq("bp_second_valid", resp_valid, 1);
    check_eq("bp_second_data", resp_data, 8'h00);
    step();
    check_eq("bp_drained", resp_valid, 0);

    // 4. out-of-range write dropped, read returns zero
    do_write(4'd13, 8'h77, 1'b0);
    check_eq("oor_mem13", mem[13], 8'hFF);
    read_check(4'd13, 8'h00);
    for (int i = 0; i < DEPTH; i++) read_check(AW'(i), (i == 3) ? 8'hA5 : 8'h00);

    // 5. back-to-back reads
    do_write(4'd0, 8'h11, 1'b1);
    do_write(4'd1, 8'h22, 1'b1);
    do_write(4'd2, 8'h33, 1'b1);
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
      exp_q.push_back(8'h11 * (i + 1));
      #1;
      check_eq("b2b_ready", req_ready, 1);
      step();
      check_eq("b2b_valid", resp_valid, 1);
      check_eq("b2b_data", resp_data, exp_q.pop_front());
    end
    idle_req();
    step();
    check_eq("b2b_drained", resp_valid, 0);

    // 6a. reset with a pending response
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
    step();
    idle_req();
    check_eq("pend_valid", resp_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    check_eq("rst_drops_valid", resp_valid, 0);
    check_eq("rst_clears_data", resp_data, 0);
    check_eq("rst_addr0", ram_addr, 0);
    // 6b. reset again during sweep cycle 5
    for (int i = 0; i < 5; i++) step();
    check_eq("mid_sweep_addr", ram_addr, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_sweep();
    read_check(4'd0, 8'h00);
    read_check(4'd3, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ram_access_ctrl
